// File: rtl/if_stage_if.sv
// Fetch-stage port bundle: pipeline control, loader write port and decode-side outputs.
// Latency: none; this is only wiring shared by the fetch stage and whatever drives it.
// Backpressure: carried by stall/stall_dly (the fetch side holds while stall is high).
//
// Modports:
//   master - pipeline/loader side: drives control and loader signals, observes inst_id/pc_id/fetch_cnt.
//   slave  - fetch stage side.
interface if_stage_if #(
    parameter int IWIDTH = 12
) ();
    logic              cpu_run;
    logic              jmp_condition_ex;
    logic [29:0]       jmp_adr_ex;
    logic              stall;
    logic              stall_dly;
    logic              rst_pipe;
    logic [IWIDTH-1:0] imem_wadr;
    logic [31:0]       imem_wdata;
    logic              imem_wen;
    logic [31:0]       inst_id;
    logic [29:0]       pc_id;
    logic [31:0]       fetch_cnt;

    modport master (
        output cpu_run, jmp_condition_ex, jmp_adr_ex, stall, stall_dly, rst_pipe,
        output imem_wadr, imem_wdata, imem_wen,
        input  inst_id, pc_id, fetch_cnt
    );

    modport slave (
        input  cpu_run, jmp_condition_ex, jmp_adr_ex, stall, stall_dly, rst_pipe,
        input  imem_wadr, imem_wdata, imem_wen,
        output inst_id, pc_id, fetch_cnt
    );
endinterface

// File: rtl/if_stage.sv
// RV32I instruction fetch: holds the fetch PC, reads the instruction RAM, issues inst_id/pc_id to decode.
// Latency: one cycle from PC to inst_id; a taken jump costs one NOP bubble before the target appears.
// Backpressure: stall freezes both PCs; inst_id is held constant from the first stall cycle through the first release cycle.
//
// Ports: clk, rst_n (async active-low), bus (if_stage_if.slave):
//   inputs  cpu_run, jmp_condition_ex, jmp_adr_ex[29:0], stall, stall_dly, rst_pipe,
//           imem_wadr[IWIDTH-1:0], imem_wdata[31:0], imem_wen
//   outputs inst_id[31:0], pc_id[29:0], fetch_cnt[31:0]
// Optional: define IF_FETCH_CNT_EN to count issued (non-NOP) instructions on fetch_cnt; otherwise it is tied to 0.
module if_stage #(
    parameter int          IWIDTH    = 12,
    parameter logic [31:0] START_ADR = 32'h0000_0000
) (
    input  logic      clk,
    input  logic      rst_n,
    if_stage_if.slave bus
);
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [29:0] PC_RST = START_ADR[31:2];

    logic [31:0] mem [2**IWIDTH];
    logic [31:0] ram_rdata;
    logic [29:0] pc_if;
    logic [29:0] pc_id_q;
    logic        nop_sel;
    logic [31:0] inst_hold;
    logic [31:0] inst_out;
    logic        adv;
    logic        stall_first;

    assign adv         = bus.cpu_run & ~bus.stall & ~bus.rst_pipe;
    assign stall_first = bus.stall & ~bus.stall_dly;

    // The RAM is read every cycle at pc_if. While the PC is frozen the same word is
    // simply re-read, so the word issued on resume is the pc_if word. Non-blocking
    // update gives old data on a same-address write/read collision.
    always_ff @(posedge clk) begin
        if (bus.imem_wen) begin
            mem[bus.imem_wadr] <= bus.imem_wdata;
        end
        ram_rdata <= mem[pc_if[IWIDTH-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_if     <= PC_RST;
            pc_id_q   <= '0;
            nop_sel   <= 1'b1;
            inst_hold <= NOP;
        end else if (bus.rst_pipe) begin
            // Flush wins over stall and jump; inst_hold is cleared too so that a
            // still-high stall_dly next cycle presents a NOP rather than stale code.
            pc_if     <= PC_RST;
            pc_id_q   <= '0;
            nop_sel   <= 1'b1;
            inst_hold <= NOP;
        end else begin
            if (stall_first) begin
                inst_hold <= inst_out;
            end
            if (!bus.stall) begin
                if (bus.cpu_run) begin
                    pc_id_q <= pc_if;
                    pc_if   <= bus.jmp_condition_ex ? bus.jmp_adr_ex : pc_if + 30'd1;
                    // The word read alongside a taken jump is wrong-path: squash it.
                    nop_sel <= bus.jmp_condition_ex;
                end else begin
                    nop_sel <= 1'b1;
                end
            end
        end
    end

    // Only stall_dly reaches inst_id combinationally; everything else is registered.
    assign inst_out    = bus.stall_dly ? inst_hold : (nop_sel ? NOP : ram_rdata);
    assign bus.inst_id = inst_out;
    assign bus.pc_id   = pc_id_q;

`ifdef IF_FETCH_CNT_EN
    logic [31:0] fetch_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
        end else if (bus.rst_pipe) begin
            fetch_cnt_q <= '0;
        end else if (adv && !bus.jmp_condition_ex) begin
            fetch_cnt_q <= fetch_cnt_q + 32'd1;
        end
    end

    assign bus.fetch_cnt = fetch_cnt_q;
`else
    assign bus.fetch_cnt = 32'd0;
`endif

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction fetch stage of the RV32I pipeline.
- Holds the fetch PC and reads a synchronous single-port-read / single-port-write instruction RAM.
- Presents inst_id/pc_id to the instruction decode stage, one instruction per cycle.
- Handles taken-jump redirect from EX, pipeline stall hold, pipeline reset, and program loading through a write port.

Parameters:
- IWIDTH, 12, instruction RAM word-address width; depth is 2^IWIDTH words of 32 bits.
- START_ADR, 32'h0000_0000, PC after reset or rst_pipe; bits [1:0] are ignored.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- cpu_run  input  1  fetch enable; 0 = PC frozen and NOP issued.
- jmp_condition_ex  input  1  taken jump/branch resolved in EX.
- jmp_adr_ex  input  30  jump target [31:2].
- stall  input  1  pipeline stall, same signal the decode stage uses.
- stall_dly  input  1  stall delayed by one cycle.
- rst_pipe  input  1  synchronous pipeline flush to START_ADR.
- imem_wadr  input  IWIDTH  loader write word address.
- imem_wdata  input  32  loader write data.
- imem_wen  input  1  loader write enable.
- inst_id  output  32  instruction to the decode stage.
- pc_id  output  30  PC [31:2] of inst_id.
- fetch_cnt  output  32  fetched-instruction count (see Optional Feature).

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset values: pc_if = START_ADR[31:2], pc_id = 0, nop_sel = 1 (inst_id = 32'h0000_0013), inst_hold = 32'h0000_0013, fetch_cnt = 0.
- RAM read: synchronous, address pc_if[IWIDTH+1:2]. Data is valid the cycle after the address is presented, aligned with pc_id. PC bits above IWIDTH+1 are ignored, so addresses alias (wrap).
- RAM write: imem_wen writes imem_wdata at imem_wadr on the clock edge. A same-cycle read of the same address returns the old data.
- Advance condition: adv = cpu_run & ~stall & ~rst_pipe. When adv:
  - pc_id <= pc_if.
  - pc_if <= jmp_condition_ex ? jmp_adr_ex : pc_if + 1. The increment is modulo 2^30, so 30'h3FFF_FFFF wraps to 0.
- Jump redirect: on jmp_condition_ex with adv, the word fetched in the same cycle is wrong-path. The next-cycle inst_id is forced to NOP 32'h0000_0013 (nop_sel = 1) while pc_id still takes the old pc_if. The target instruction appears in inst_id two cycles after the jump cycle. Jump latency is one bubble.
- Stall:
  - While stall = 1, pc_if and pc_id hold and the NOP-select flag holds.
  - On the first stall cycle (stall & ~stall_dly), inst_hold captures the current inst_id.
  - While stall_dly = 1, inst_id = inst_hold. This makes inst_id constant for the whole stall, including the first post-stall cycle.
  - jmp_condition_ex during stall is ignored. EX is frozen and re-presents the jump once stall drops.
- cpu_run = 0 (and not stalled): PCs hold, next inst_id = NOP, pc_id unchanged. On return to 1, fetch resumes from pc_if with no lost instruction: the RAM address was held, so the first issued word is the pc_if word.
- rst_pipe (synchronous, highest priority): pc_if <= START_ADR[31:2], pc_id <= 0, next inst_id = NOP, inst_hold <= NOP. It overrides stall and jump in the same cycle.
- Priority: rst_n > rst_pipe > stall > jmp_condition_ex > sequential increment.
- Output selection: inst_id = stall_dly ? inst_hold : (nop_sel ? 32'h13 : ram_rdata). Output is registered-equivalent, with no combinational path from jmp or stall inputs to inst_id except the stall_dly mux.

Optional Feature:
- IF_FETCH_CNT_EN defined: fetch_cnt increments by 1 on each cycle where adv = 1 and the next inst_id is not a forced NOP (i.e. a real instruction issued).
  - Cleared by rst_n and rst_pipe.
  - Wraps 32'hFFFF_FFFF to 0.
- IF_FETCH_CNT_EN not defined: fetch_cnt tied to 32'd0, no counter flops.

Test Plan:
- Reset, then load RAM words 0..3 = 32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213; cpu_run = 1 -> inst_id shows NOP, then the four words in order with pc_id = 0, 1, 2, 3.
- Jump: jmp_condition_ex = 1 with jmp_adr_ex = 30'h40 while pc_if = 5 -> next cycle inst_id = 32'h13 and pc_id = 5; the cycle after that, pc_id = 30'h40 with RAM[0x40].
- Stall: assert stall for 3 cycles while inst_id = RAM[2] -> inst_id = RAM[2] and pc_id = 2 for all 3 cycles plus the first release cycle; then RAM[3] with pc_id = 3, and nothing skipped or duplicated.
- Simultaneous rst_pipe, stall and jmp_condition_ex -> next cycle pc_if = START_ADR, pc_id = 0, inst_id = 32'h13; the stall and jump are discarded.
- Wrap: START_ADR = 32'hFFFF_FFFC -> pc_if goes 30'h3FFF_FFFF to 0, RAM address aliasing holds, and fetch_cnt = 2 after two issues with IF_FETCH_CNT_EN defined (0 without).
- Mid-operation async reset: rst_n low during a stall -> all outputs go to reset values immediately; after rst_n high, fetch restarts at START_ADR.
